// File: rtl/limb_mult_pkg.sv
// rtl/limb_mult_pkg.sv - shared helpers, default sizing and state type for the limb multiplier
package limb_mult_pkg;

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    localparam int DEF_LIMB      = 16;
    localparam int DEF_A_BITS    = 130;
    localparam int DEF_B_BITS    = 128;
    localparam int DEF_PAR       = 4;
    localparam int DEF_A_LIMBS   = ceil_div(DEF_A_BITS, DEF_LIMB);
    localparam int DEF_B_LIMBS   = ceil_div(DEF_B_BITS, DEF_LIMB);
    localparam int DEF_PARTIALS  = DEF_A_LIMBS * DEF_B_LIMBS;
    localparam int DEF_N_CYC     = ceil_div(DEF_PARTIALS, DEF_PAR);
    localparam int DEF_OUT_BITS  = DEF_A_BITS + DEF_B_BITS + 1;

    typedef enum logic {
        IDLE    = 1'b0,
        COMPUTE = 1'b1
    } state_t;

endpackage

// File: rtl/limb_pp_lane.sv
// rtl/limb_pp_lane.sv - one LIMB x LIMB partial product placed at its limb weight
module limb_pp_lane #(
    parameter int LIMB     = 16,
    parameter int SH_W     = 5,
    parameter int OUT_BITS = 259
) (
    input  logic                lane_valid,
    input  logic [LIMB-1:0]     a_limb,
    input  logic [LIMB-1:0]     b_limb,
    input  logic [SH_W-1:0]     limb_shift,
    output logic [OUT_BITS-1:0] term
);

    logic [2*LIMB-1:0]   prod;
    logic [OUT_BITS-1:0] prod_ext;

    always_comb begin
        prod     = {{LIMB{1'b0}}, a_limb} * {{LIMB{1'b0}}, b_limb};
        prod_ext = '0;
        prod_ext[2*LIMB-1:0] = prod;
        // Lanes past the last partial contribute nothing to the sum.
        term = lane_valid ? (prod_ext << (32'(limb_shift) * LIMB)) : '0;
    end

endmodule

// File: rtl/limb_mult_acc.sv
// rtl/limb_mult_acc.sv - multi-cycle limb multiplier with optional addend
module limb_mult_acc
    import limb_mult_pkg::*;
#(
    parameter int LIMB          = DEF_LIMB,
    parameter int A_BITS        = DEF_A_BITS,
    parameter int B_BITS        = DEF_B_BITS,
    parameter int PAR_PER_CYCLE = DEF_PAR
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     acc_mode,
    input  logic                     abort,
    input  logic [A_BITS-1:0]        a_in,
    input  logic [B_BITS-1:0]        b_in,
    input  logic [A_BITS+B_BITS-1:0] c_in,
    output logic [A_BITS+B_BITS:0]   product_out,
    output logic                     busy,
    output logic                     done
);

    localparam int A_LIMBS  = ceil_div(A_BITS, LIMB);
    localparam int B_LIMBS  = ceil_div(B_BITS, LIMB);
    localparam int TOTAL    = A_LIMBS * B_LIMBS;
    localparam int OUT_BITS = A_BITS + B_BITS + 1;
    localparam int IDX_W    = $clog2(TOTAL + 1);
    localparam int AI_W     = (A_LIMBS > 1) ? $clog2(A_LIMBS) : 1;
    localparam int BJ_W     = (B_LIMBS > 1) ? $clog2(B_LIMBS) : 1;
    localparam int SH_W     = $clog2(A_LIMBS + B_LIMBS);

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    idx;
    logic [OUT_BITS-1:0] acc, acc_nxt, pp_sum;
    logic [OUT_BITS-1:0] terms [PAR_PER_CYCLE];
    logic [LIMB-1:0]     a_limb [A_LIMBS];
    logic [LIMB-1:0]     b_limb [B_LIMBS];
    logic [A_LIMBS*LIMB-1:0] a_pad;
    logic [B_LIMBS*LIMB-1:0] b_pad;
    logic                last, accept, finish;

    always_comb begin
        a_pad = '0;
        a_pad[A_BITS-1:0] = a_in;
        b_pad = '0;
        b_pad[B_BITS-1:0] = b_in;
    end

    // Partial k maps row-major to limb pair (k / B_LIMBS, k % B_LIMBS).
    for (genvar l = 0; l < PAR_PER_CYCLE; l++) begin : g_lane
        logic [31:0]     k;
        logic            valid;
        logic [AI_W-1:0] ai;
        logic [BJ_W-1:0] bj;
        logic [SH_W-1:0] sh;

        always_comb begin
            k     = 32'(idx) + 32'(l);
            valid = k < 32'(TOTAL);
            ai    = valid ? AI_W'(k / 32'(B_LIMBS)) : '0;
            bj    = valid ? BJ_W'(k % 32'(B_LIMBS)) : '0;
            sh    = SH_W'(ai) + SH_W'(bj);
        end

        limb_pp_lane #(
            .LIMB     (LIMB),
            .SH_W     (SH_W),
            .OUT_BITS (OUT_BITS)
        ) u_lane (
            .lane_valid (valid),
            .a_limb     (a_limb[ai]),
            .b_limb     (b_limb[bj]),
            .limb_shift (sh),
            .term       (terms[l])
        );
    end

    always_comb begin
        pp_sum = '0;
        for (int l = 0; l < PAR_PER_CYCLE; l++) begin
            pp_sum = pp_sum + terms[l];
        end
        acc_nxt = acc + pp_sum;
        last    = (32'(idx) + 32'(PAR_PER_CYCLE)) >= 32'(TOTAL);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = COMPUTE;
            COMPUTE: if (abort || last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == COMPUTE);
        accept = (state == IDLE) && start;
        finish = (state == COMPUTE) && last && !abort;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc         <= '0;
            idx         <= '0;
            product_out <= '0;
            done        <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                acc <= acc_mode ? OUT_BITS'(c_in) : '0;
                idx <= '0;
            end else if (state == COMPUTE) begin
                acc <= acc_nxt;
                idx <= idx + IDX_W'(PAR_PER_CYCLE);
                if (finish) product_out <= acc_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < A_LIMBS; i++) a_limb[i] <= a_pad[i*LIMB +: LIMB];
            for (int j = 0; j < B_LIMBS; j++) b_limb[j] <= b_pad[j*LIMB +: LIMB];
        end
    end

endmodule

// File: tb/tb_limb_mult_acc.sv
// tb/tb_limb_mult_acc.sv - randomized bench for limb_mult_acc against an arithmetic reference
module tb_limb_mult_acc;

    localparam int N_CYC = 18;

    logic         clk = 1'b0;
    logic         reset_n, rst_sw_n;
    logic         start, acc_mode, abort;
    logic [129:0] a_in;
    logic [127:0] b_in;
    logic [257:0] c_in;
    logic [258:0] product_out;
    logic         busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    limb_mult_acc #(
        .LIMB          (16),
        .A_BITS        (130),
        .B_BITS        (128),
        .PAR_PER_CYCLE (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .acc_mode    (acc_mode),
        .abort       (abort),
        .a_in        (a_in),
        .b_in        (b_in),
        .c_in        (c_in),
        .product_out (product_out),
        .busy        (busy),
        .done        (done)
    );

    task automatic check(input string tag, input logic [258:0] got, input logic [258:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [319:0] rnd_wide();
        logic [319:0] r = '0;
        for (int i = 0; i < 10; i++) r = {r[287:0], $urandom};
        return r;
    endfunction

    function automatic logic [258:0] ref_mac(input logic [129:0] a, input logic [127:0] b,
                                             input logic [257:0] c, input logic m);
        logic [258:0] p;
        p = 259'(a) * 259'(b);
        if (m) p = p + 259'(c);
        return p;
    endfunction

    // Called just after a negedge; returns at the negedge following the accept edge.
    task automatic launch(input logic [129:0] a, input logic [127:0] b, input logic [257:0] c,
                          input logic m, input logic ab);
        a_in = a; b_in = b; c_in = c; acc_mode = m; abort = ab; start = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        a_in = 130'(rnd_wide()); b_in = 128'(rnd_wide()); c_in = 258'(rnd_wide()); acc_mode = ~m;
    endtask

    task automatic wait_done(output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = busy ? 1 : 0;
        do begin
            @(negedge clk);
            cyc++;
            if (busy) bcnt++;
        end while (!done && cyc < 500);
    endtask

    task automatic run_op(input string tag, input logic [129:0] a, input logic [127:0] b,
                          input logic [257:0] c, input logic m);
        int cyc, bcnt;
        launch(a, b, c, m, 1'b0);
        wait_done(cyc, bcnt);
        check({tag, "_lat"}, 259'(cyc), 259'(N_CYC));
        check({tag, "_prod"}, product_out, ref_mac(a, b, c, m));
    endtask

    task automatic watch_no_done(input string tag, input int n);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check(tag, 259'(seen), 259'(0));
    endtask

    // Small-width instances with different lane counts, each with its own stimulus loop.
    for (genvar gi = 0; gi < 4; gi++) begin : g_sw
        localparam int P  = (gi == 0) ? 1 : (gi == 1) ? 3 : (gi == 2) ? 4 : 72;
        localparam int NC = (((17 + 7) / 8) * ((33 + 7) / 8) + P - 1) / P;

        logic        s_start, s_mode, s_abort, s_busy, s_done, fin;
        logic [16:0] s_a;
        logic [32:0] s_b;
        logic [49:0] s_c;
        logic [50:0] s_p;

        limb_mult_acc #(
            .LIMB          (8),
            .A_BITS        (17),
            .B_BITS        (33),
            .PAR_PER_CYCLE (P)
        ) u_sw (
            .clk         (clk),
            .reset_n     (rst_sw_n),
            .start       (s_start),
            .acc_mode    (s_mode),
            .abort       (s_abort),
            .a_in        (s_a),
            .b_in        (s_b),
            .c_in        (s_c),
            .product_out (s_p),
            .busy        (s_busy),
            .done        (s_done)
        );

        initial begin
            logic [16:0] ra;
            logic [32:0] rb;
            logic [49:0] rc;
            logic        rm;
            logic [50:0] exp;
            int          cyc;
            fin = 1'b0; s_start = 1'b0; s_mode = 1'b0; s_abort = 1'b0;
            s_a = '0; s_b = '0; s_c = '0;
            wait (rst_sw_n === 1'b1);
            @(negedge clk);
            for (int t = 0; t < 8; t++) begin
                ra = 17'($urandom); rb = 33'({$urandom, $urandom});
                rc = 50'({$urandom, $urandom}); rm = 1'($urandom_range(0, 1));
                if (t == 0) begin
                    ra = '1; rb = '1; rc = '1; rm = 1'b1;
                end
                exp = 51'(ra) * 51'(rb) + (rm ? 51'(rc) : 51'd0);
                s_a = ra; s_b = rb; s_c = rc; s_mode = rm; s_start = 1'b1;
                @(negedge clk);
                s_start = 1'b0; s_a = 17'($urandom); s_b = 33'($urandom); s_mode = ~rm;
                cyc = 0;
                do begin
                    @(negedge clk);
                    cyc++;
                end while (!s_done && cyc < 200);
                check($sformatf("sw_p%0d_lat", P), 259'(cyc), 259'(NC));
                check($sformatf("sw_p%0d_prod", P), 259'(s_p), 259'(exp));
            end
            fin = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc, bcnt, w;
        logic [129:0] ra;
        logic [127:0] rb;
        logic [257:0] rc;
        logic [258:0] prev, exp1;

        reset_n = 1'b0; rst_sw_n = 1'b0;
        start = 1'b0; acc_mode = 1'b0; abort = 1'b0;
        a_in = '0; b_in = '0; c_in = '0;
        repeat (3) @(negedge clk);
        check("rst_prod", product_out, 259'(0));
        check("rst_busy", 259'(busy), 259'(0));
        check("rst_done", 259'(done), 259'(0));
        reset_n = 1'b1; rst_sw_n = 1'b1;
        @(negedge clk);

        launch(130'd3, 128'd5, 258'd0, 1'b0, 1'b0);
        wait_done(cyc, bcnt);
        check("small_lat", 259'(cyc), 259'(N_CYC));
        check("small_prod", product_out, 259'd15);
        check("small_busy_cycles", 259'(bcnt), 259'(N_CYC));
        @(negedge clk);
        check("done_pulse", 259'(done), 259'(0));

        run_op("max", '1, '1, '1, 1'b1);
        check("max_msb", 259'(product_out[258]), 259'(1));

        for (int t = 0; t < 6; t++) begin
            run_op($sformatf("rnd%0d", t), 130'(rnd_wide()), 128'(rnd_wide()),
                   258'(rnd_wide()), 1'($urandom_range(0, 1)));
        end

        // Start held high across done: the next op is taken right after done.
        ra = 130'(rnd_wide()); rb = 128'(rnd_wide()); rc = 258'(rnd_wide());
        exp1 = ref_mac(ra, rb, rc, 1'b1);
        a_in = ra; b_in = rb; c_in = rc; acc_mode = 1'b1; start = 1'b1;
        @(negedge clk);
        ra = 130'(rnd_wide()); rb = 128'(rnd_wide()); rc = 258'(rnd_wide());
        a_in = ra; b_in = rb; c_in = rc; acc_mode = 1'b0;
        wait_done(cyc, bcnt);
        check("b2b_lat1", 259'(cyc), 259'(N_CYC));
        check("b2b_prod1", product_out, exp1);
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy2", 259'(busy), 259'(1));
        wait_done(cyc, bcnt);
        check("b2b_lat2", 259'(cyc), 259'(N_CYC));
        check("b2b_prod2", product_out, ref_mac(ra, rb, rc, 1'b0));
        watch_no_done("b2b_no_extra", 5);
        check("b2b_idle", 259'(busy), 259'(0));

        prev = product_out;
        launch(130'(rnd_wide()), 128'(rnd_wide()), 258'(rnd_wide()), 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort5_busy", 259'(busy), 259'(0));
        check("abort5_done", 259'(done), 259'(0));
        check("abort5_prod", product_out, prev);
        watch_no_done("abort5_no_done", 25);

        launch(130'(rnd_wide()), 128'(rnd_wide()), 258'(rnd_wide()), 1'b0, 1'b0);
        repeat (N_CYC - 1) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abortf_busy", 259'(busy), 259'(0));
        check("abortf_done", 259'(done), 259'(0));
        check("abortf_prod", product_out, prev);
        watch_no_done("abortf_no_done", 5);

        ra = 130'(rnd_wide()); rb = 128'(rnd_wide()); rc = 258'(rnd_wide());
        launch(ra, rb, rc, 1'b1, 1'b1);
        check("abort_start_busy", 259'(busy), 259'(1));
        wait_done(cyc, bcnt);
        check("abort_start_lat", 259'(cyc), 259'(N_CYC));
        check("abort_start_prod", product_out, ref_mac(ra, rb, rc, 1'b1));

        launch(130'(rnd_wide()), 128'(rnd_wide()), 258'(rnd_wide()), 1'b1, 1'b0);
        repeat (7) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("midrst_prod", product_out, 259'(0));
        check("midrst_busy", 259'(busy), 259'(0));
        check("midrst_done", 259'(done), 259'(0));
        run_op("post_rst", 130'(rnd_wide()), 128'(rnd_wide()), 258'(rnd_wide()), 1'b1);

        w = 0;
        while (!(g_sw[0].fin && g_sw[1].fin && g_sw[2].fin && g_sw[3].fin) && w < 3000) begin
            @(negedge clk);
            w++;
        end
        check("sweep_complete",
              259'(g_sw[0].fin && g_sw[1].fin && g_sw[2].fin && g_sw[3].fin), 259'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
